// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults, colour type and
// constants, pixel memory dimension and the sync/blank control bundle.
package vga_pkg;

  localparam int CNT_W      = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  // Side length of the square 1-bit pixel memory.
  localparam int MEM_DIM    = 512;

  typedef logic [11:0] color_t;

  localparam color_t COLOR_WHITE = 12'hFFF;
  localparam color_t COLOR_BLACK = 12'h000;
  localparam color_t COLOR_BLUE  = 12'h00F;

  // Control bits that travel alongside the memory read.
  typedef struct packed {
    logic active;
    logic in_mem;
    logic hs_n;
    logic vs_n;
  } scan_ctl_t;

  // Blanked, sync inactive: the state the pins must show out of reset.
  localparam scan_ctl_t SCAN_CTL_IDLE = '{active: 1'b0, in_mem: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with an asynchronous active-low clear to a
// parameterised value.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; clear every stage on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= CLEAR_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_reader.sv
// Raster scanner for the 512x512x1 pixel memory: drives the read address,
// realigns the returned bit with delayed sync/blank and drives the VGA pins.
module vga_scan_reader
  import vga_pkg::*;
#(
  parameter int     H_ACTIVE     = H_ACTIVE_D,
  parameter int     H_FP         = H_FP_D,
  parameter int     H_SYNC       = H_SYNC_D,
  parameter int     H_BP         = H_BP_D,
  parameter int     V_ACTIVE     = V_ACTIVE_D,
  parameter int     V_FP         = V_FP_D,
  parameter int     V_SYNC       = V_SYNC_D,
  parameter int     V_BP         = V_BP_D,
  parameter int     MEM_LATENCY  = 2,
  parameter color_t FG_COLOR     = COLOR_WHITE,
  parameter color_t BG_COLOR     = COLOR_BLACK,
  parameter color_t BORDER_COLOR = COLOR_BLUE
) (
  input  logic       read_clk,
  input  logic       resetn,
  output logic [9:0] read_x,
  output logic [9:0] read_y,
  input  logic       read_color,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] MEM_END    = CNT_W'(MEM_DIM);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             run_q;
  logic             frame_start_q, frame_start_d;
  scan_ctl_t        ctl_s0;
  scan_ctl_t        ctl_aligned;
  color_t           color_q, color_d;
  logic             hs_q, vs_q;

  // Next raster position; the first edge after reset holds (0,0) so the
  // address phase of pixel (0,0) is as long as any other.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
    frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  // Counter stage: raster position and the address-phase frame marker.
  always_ff @(posedge read_clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      run_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      run_q         <= 1'b1;
      frame_start_q <= frame_start_d;
    end
  end

  // Decode blanking, memory window and syncs for the address being read.
  always_comb begin
    ctl_s0.active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    ctl_s0.in_mem = ctl_s0.active && (h_cnt_q < MEM_END);
    ctl_s0.hs_n   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    ctl_s0.vs_n   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
  end

  // Delay the control bits by the memory latency so they meet read_color.
  delay_line #(
    .WIDTH    (4),
    .DEPTH    (MEM_LATENCY),
    .CLEAR_VAL(SCAN_CTL_IDLE)
  ) u_ctl_delay (
    .clk_i (read_clk),
    .rst_ni(resetn),
    .d_i   (ctl_s0),
    .q_o   (ctl_aligned)
  );

  // Colour select; past column 511 the memory address aliases, so the
  // data bit is ignored there and the border colour is shown instead.
  always_comb begin
    color_d = COLOR_BLACK;
    if (!ctl_aligned.active) begin
      color_d = COLOR_BLACK;
    end else if (ctl_aligned.in_mem) begin
      color_d = read_color ? FG_COLOR : BG_COLOR;
    end else begin
      color_d = BORDER_COLOR;
    end
  end

  // Output register: colour and syncs leave on the same edge.
  always_ff @(posedge read_clk or negedge resetn) begin
    if (!resetn) begin
      color_q <= COLOR_BLACK;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      color_q <= color_d;
      hs_q    <= ctl_aligned.hs_n;
      vs_q    <= ctl_aligned.vs_n;
    end
  end

  assign read_x      = h_cnt_q;
  assign read_y      = v_cnt_q;
  assign frame_start = frame_start_q;
  assign vga_r       = color_q[11:8];
  assign vga_g       = color_q[7:4];
  assign vga_b       = color_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Bench for vga_scan_reader: two instances (memory latency 2 and 1) with a
// shortened vertical timing (19 lines) and the default horizontal timing.
module tb_vga_scan_reader;
  import vga_pkg::*;

  localparam int HT    = 800;
  localparam int VT    = 19;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       mode;  // 0: memory holds a single 1 at (5,7); 1: all ones
  logic [9:0] rx2, ry2, rx1, ry1;
  logic       rc2, rc1;
  logic [3:0] r2, g2, b2, r1, g1, b1;
  logic       hs2, vs2, hs1, vs1, fs2, fs1;

  vga_scan_reader #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .MEM_LATENCY(2)
  ) dut (
    .read_clk(clk), .resetn(resetn), .read_x(rx2), .read_y(ry2),
    .read_color(rc2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .vga_hs(hs2), .vga_vs(vs2), .frame_start(fs2)
  );

  vga_scan_reader #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .MEM_LATENCY(1)
  ) dut1 (
    .read_clk(clk), .resetn(resetn), .read_x(rx1), .read_y(ry1),
    .read_color(rc1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs(hs1), .vga_vs(vs1), .frame_start(fs1)
  );

  // Memory models: the memory sees only the low 9 address bits.
  function automatic logic mem_bit(logic m, logic [9:0] x, logic [9:0] y);
    return m ? 1'b1 : ((x[8:0] == 9'd5) && (y[8:0] == 9'd7));
  endfunction

  logic [1:0] m2_q = '0;
  logic       m1_q = 1'b0;
  always @(posedge clk) begin
    m2_q[0] <= mem_bit(mode, rx2, ry2);
    m2_q[1] <= m2_q[0];
    m1_q    <= mem_bit(mode, rx1, ry1);
  end
  assign rc2 = m2_q[1];
  assign rc1 = m1_q;

  // Edge index since release: after edge n the address is raster position n.
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= -1;
    else         cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic goto(int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 100000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < n) check("goto_timeout", cyc, n);
  endtask

  task automatic do_reset(logic m);
    @(negedge clk);
    resetn = 1'b0;
    mode   = m;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_read_x"},  32'(rx2), 32'd0);
    check({tag, "_read_y"},  32'(ry2), 32'd0);
    check({tag, "_rgb"},     32'({r2, g2, b2}), 32'h000);
    check({tag, "_hs"},      32'(hs2), 32'd1);
    check({tag, "_vs"},      32'(vs2), 32'd1);
    check({tag, "_fstart"},  32'(fs2), 32'd0);
    check({tag, "_rgb_l1"},  32'({r1, g1, b1}), 32'h000);
    check({tag, "_hs_l1"},   32'(hs1), 32'd1);
  endtask

  typedef struct {
    logic       mode;
    int         x;
    int         y;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int hs_first, hs1_first, hs_last, hs_falls, hs_per_err, hs_low_err;
  int vs_first, vs_last, vs_falls, vs_per_err, vs_low_err;
  int x_err, y_err, fs_err, fs_cnt;
  logic hs_prev, vs_prev;

  initial begin
    // mode, x, y, expected rgb at pins, expected hs, expected vs
    vecs[0]  = '{1'b0,   5,  6, 12'h000, 1'b1, 1'b1};
    vecs[1]  = '{1'b0,   4,  7, 12'h000, 1'b1, 1'b1};
    vecs[2]  = '{1'b0,   5,  7, 12'hFFF, 1'b1, 1'b1};
    vecs[3]  = '{1'b0,   6,  7, 12'h000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 517,  7, 12'h00F, 1'b1, 1'b1};
    vecs[5]  = '{1'b0,   5,  8, 12'h000, 1'b1, 1'b1};
    vecs[6]  = '{1'b1,   0,  0, 12'hFFF, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 511,  3, 12'hFFF, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 512,  3, 12'h00F, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 639,  3, 12'h00F, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 640,  3, 12'h000, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 655,  3, 12'h000, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 656,  3, 12'h000, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 751,  3, 12'h000, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 752,  3, 12'h000, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 799,  3, 12'h000, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 100, 11, 12'hFFF, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 100, 12, 12'h000, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 799, 13, 12'h000, 1'b1, 1'b1};
    vecs[19] = '{1'b1,   0, 14, 12'h000, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 656, 15, 12'h000, 1'b0, 1'b0};
    vecs[21] = '{1'b1,   0, 16, 12'h000, 1'b1, 1'b1};

    // Reset values
    resetn = 1'b0;
    mode   = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("reset");
    resetn = 1'b1;

    // First edges after release
    goto(0);
    check("rel0_read_x", 32'(rx2), 32'd0);
    check("rel0_fstart", 32'(fs2), 32'd1);
    goto(1);
    check("rel1_read_x", 32'(rx2), 32'd1);
    check("rel1_fstart", 32'(fs2), 32'd0);

    // Two frames: raster counters, frame marker, sync timing
    hs_first = -1; hs1_first = -1; hs_last = -1; hs_falls = 0; hs_per_err = 0; hs_low_err = 0;
    vs_first = -1; vs_last = -1; vs_falls = 0; vs_per_err = 0; vs_low_err = 0;
    x_err = 0; y_err = 0; fs_err = 0; fs_cnt = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    for (int n = 2; n <= 2 * FRAME + 10; n++) begin
      goto(n);
      if (int'(rx2) != n % HT) x_err++;
      if (int'(ry2) != (n / HT) % VT) y_err++;
      if (fs2 != (n % FRAME == 0)) fs_err++;
      if (fs2) fs_cnt++;
      if (n == FRAME - 1) check("wrap_before_xy", {12'd0, rx2, ry2}, {12'd0, 10'd799, 10'd18});
      if (n == FRAME)     check("wrap_after_xyf", {11'd0, rx2, ry2, fs2}, {11'd0, 10'd0, 10'd0, 1'b1});
      if (n == FRAME + 1) check("wrap_fstart_end", 32'(fs2), 32'd0);
      if (hs_prev && !hs2) begin
        hs_falls++;
        if (hs_last < 0) hs_first = n;
        else if (n - hs_last != HT) hs_per_err++;
        hs_last = n;
      end
      if (!hs_prev && hs2 && hs_last >= 0 && (n - hs_last != 96)) hs_low_err++;
      if (vs_prev && !vs2) begin
        vs_falls++;
        if (vs_last < 0) vs_first = n;
        else if (n - vs_last != FRAME) vs_per_err++;
        vs_last = n;
      end
      if (!vs_prev && vs2 && vs_last >= 0 && (n - vs_last != 2 * HT)) vs_low_err++;
      if (hs1_first < 0 && !hs1) hs1_first = n;
      hs_prev = hs2;
      vs_prev = vs2;
    end
    $display("frames: hs_first=%0d hs_falls=%0d vs_first=%0d vs_falls=%0d", hs_first, hs_falls, vs_first, vs_falls);
    check("raster_x_errors",   x_err, 0);
    check("raster_y_errors",   y_err, 0);
    check("fstart_errors",     fs_err, 0);
    check("fstart_count",      fs_cnt, 2);
    check("hs_first_fall",     hs_first, 659);
    check("hs_first_fall_l1",  hs1_first, 658);
    check("hs_fall_count",     hs_falls, 38);
    check("hs_period_errors",  hs_per_err, 0);
    check("hs_low_errors",     hs_low_err, 0);
    check("vs_first_fall",     vs_first, 14 * HT + 3);
    check("vs_fall_count",     vs_falls, 2);
    check("vs_period_errors",  vs_per_err, 0);
    check("vs_low_errors",     vs_low_err, 0);

    // Table-driven pixel and sync checks at the pins
    for (int i = 0; i < NV; i++) begin
      int pos;
      if (i == 0 || vecs[i].mode != vecs[i-1].mode) do_reset(vecs[i].mode);
      pos = vecs[i].y * HT + vecs[i].x;
      goto(pos + 2);
      check($sformatf("vec%0d_rgb_l1", i), 32'({r1, g1, b1}), 32'(vecs[i].rgb));
      goto(pos + 3);
      $display("vec %0d mode=%0d (%0d,%0d) rgb=%03h hs=%0b vs=%0b", i, vecs[i].mode,
               vecs[i].x, vecs[i].y, {r2, g2, b2}, hs2, vs2);
      check($sformatf("vec%0d_rgb", i), 32'({r2, g2, b2}), 32'(vecs[i].rgb));
      check($sformatf("vec%0d_hs", i),  32'(hs2), 32'(vecs[i].hs));
      check($sformatf("vec%0d_vs", i),  32'(vs2), 32'(vecs[i].vs));
    end

    // Asynchronous reset in the middle of a line
    do_reset(1'b1);
    goto(10 * HT + 300);
    check("mid_read_x", 32'(rx2), 32'd300);
    check("mid_read_y", 32'(ry2), 32'd10);
    check("mid_rgb",    32'({r2, g2, b2}), 32'hFFF);
    resetn = 1'b0;
    #1;
    check_idle("async");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    goto(0);
    check("restart_xyf", {11'd0, rx2, ry2, fs2}, {11'd0, 10'd0, 10'd0, 1'b1});
    hs_first = -1;
    for (int n = 1; n < 2000 && hs_first < 0; n++) begin
      goto(n);
      if (!hs2) hs_first = n;
    end
    check("restart_hs_first", hs_first, 659);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
